// File: rtl/dsp_mac_sequencer_pkg.sv
// dsp_seq_pkg: shared constants and types for the DSP48A1 MAC sequencer.
//   - OPMODE encodings presented to the slice (X=M, Z=0 / Z=P / idle)
//   - tag_t: per-issue tag {valid, first, last} carried down the slice pipeline
//   - operand and P widths of the DSP48A1 slice
package dsp_seq_pkg;

   localparam int OPND_W = 18;
   localparam int P_W    = 48;

   // OPMODE[1:0] selects X, OPMODE[3:2] selects Z; pre-adder unused (add mode)
   localparam logic [7:0] OPM_LOAD = 8'h01;   // X=M, Z=0
   localparam logic [7:0] OPM_ACC  = 8'h09;   // X=M, Z=P
   localparam logic [7:0] OPM_IDLE = 8'h00;

   typedef struct packed {
      logic valid;
      logic first;
      logic last;
   } tag_t;

   localparam int TAG_W = $bits(tag_t);

   // OPMODE for the post-adder stage given the tag sitting at that stage
   function automatic logic [7:0] tag_opmode(input tag_t t);
      logic [7:0] opm;
      if (!t.valid) begin
         opm = OPM_IDLE;
      end else if (t.first) begin
         opm = OPM_LOAD;
      end else begin
         opm = OPM_ACC;
      end
      return opm;
   endfunction

endpackage

// File: rtl/dsp_mac_sequencer_valid_pipe.sv
// valid_pipe: fixed-depth shift register, shifts every cycle (no enable).
// Ports:
//   clk, rst_n  clock and asynchronous active-low clear
//   din         word entering stage 1
//   stages      all stage contents; stages[0] is stage 1, stages[DEPTH-1] is stage DEPTH
module valid_pipe
   import dsp_seq_pkg::*;
#(
   parameter int DEPTH = 3,
   parameter int WIDTH = TAG_W
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [WIDTH-1:0]             din,
   output logic [DEPTH-1:0][WIDTH-1:0]  stages
);

   logic [DEPTH-1:0][WIDTH-1:0] pipe_r;

   // Shift register: new word into stage 1, every stage advances each cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_r <= '0;
      end else begin
         pipe_r[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            pipe_r[i] <= pipe_r[i-1];
         end
      end
   end

   assign stages = pipe_r;

endmodule

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: feeds operand pairs into a DSP48A1 slice configured for
// multiply-accumulate, gates its A/B, M and P clock enables in step with each
// accepted element, and captures P after the last element of every vector.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cfg_len                    elements per vector (0 means 1), sampled on element 0
//   in_valid/in_ready/in_a/in_b  operand stream (signed 18-bit)
//   dsp_a/b/c/d, dsp_opmode    slice data inputs and OPMODE
//   dsp_cea/ceb/cem/cep        slice per-stage clock enables
//   dsp_p                      slice P output
//   out_valid/out_ready/out_data  dot-product result stream
module dsp_mac_sequencer
   import dsp_seq_pkg::*;
#(
   parameter int LEN_W        = 8,
   parameter int LATENCY      = 3,
   parameter int OPMODE_DELAY = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [LEN_W-1:0]  cfg_len,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OPND_W-1:0] in_a,
   input  logic [OPND_W-1:0] in_b,
   output logic [OPND_W-1:0] dsp_a,
   output logic [OPND_W-1:0] dsp_b,
   output logic [P_W-1:0]    dsp_c,
   output logic [OPND_W-1:0] dsp_d,
   output logic [7:0]        dsp_opmode,
   output logic              dsp_cea,
   output logic              dsp_ceb,
   output logic              dsp_cem,
   output logic              dsp_cep,
   input  logic [P_W-1:0]    dsp_p,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [P_W-1:0]    out_data
);

   logic [LEN_W-1:0]              elem_cnt_r;
   logic [LEN_W-1:0]              len_r;
   logic [LEN_W-1:0]              cur_len_s;
   logic                          first_s;
   logic                          last_s;
   logic                          issue_s;
   logic                          in_ready_s;
   logic                          last_in_pipe_s;
   logic                          capture_s;
   logic                          unused_first_s;
   tag_t                          issue_tag_s;
   tag_t                          stage_tag_s [LATENCY];
   logic [LATENCY-1:0][TAG_W-1:0] stages_s;
   logic                          out_valid_r;
   logic [P_W-1:0]                out_data_r;

   // Vector length in force for the element about to issue; element 0 uses cfg_len
   always_comb begin
      cur_len_s = len_r;
      if (elem_cnt_r == {LEN_W{1'b0}}) begin
         if (cfg_len == {LEN_W{1'b0}}) begin
            cur_len_s = {{(LEN_W-1){1'b0}}, 1'b1};
         end else begin
            cur_len_s = cfg_len;
         end
      end else begin
         cur_len_s = len_r;
      end
   end

   assign first_s = (elem_cnt_r == {LEN_W{1'b0}});
   assign last_s  = (elem_cnt_r == (cur_len_s - {{(LEN_W-1){1'b0}}, 1'b1}));

   // Unpack the pipe and look for an in-flight last element
   always_comb begin
      last_in_pipe_s = 1'b0;
      unused_first_s = 1'b0;
      for (int i = 0; i < LATENCY; i++) begin
         stage_tag_s[i] = tag_t'(stages_s[i]);
      end
      for (int i = 0; i < LATENCY; i++) begin
         if (stage_tag_s[i].valid && stage_tag_s[i].last) begin
            last_in_pipe_s = 1'b1;
         end else begin
            last_in_pipe_s = last_in_pipe_s;
         end
         if (i != OPMODE_DELAY - 1) begin
            unused_first_s = unused_first_s ^ stage_tag_s[i].first;
         end else begin
            unused_first_s = unused_first_s;
         end
      end
   end

   // Only one last element may be in flight or held; a held result blocks the next last
   always_comb begin
      in_ready_s = 1'b1;
      if (last_s && (last_in_pipe_s || (out_valid_r && !out_ready))) begin
         in_ready_s = 1'b0;
      end else begin
         in_ready_s = 1'b1;
      end
   end

   // No issue while reset is asserted so the slice sees idle inputs immediately
   assign issue_s = in_valid && in_ready_s && rst_n;

   always_comb begin
      issue_tag_s       = '0;
      issue_tag_s.valid = issue_s;
      issue_tag_s.first = issue_s && first_s;
      issue_tag_s.last  = issue_s && last_s;
   end

   valid_pipe #(
      .DEPTH (LATENCY),
      .WIDTH (TAG_W)
   ) u_tag_pipe (
      .clk    (clk),
      .rst_n  (rst_n),
      .din    (issue_tag_s),
      .stages (stages_s)
   );

   // Element counter and length latch; the last element wraps back to 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         elem_cnt_r <= {LEN_W{1'b0}};
         len_r      <= {LEN_W{1'b0}};
      end else if (issue_s) begin
         if (first_s) begin
            len_r <= cur_len_s;
         end else begin
            len_r <= len_r;
         end
         if (last_s) begin
            elem_cnt_r <= {LEN_W{1'b0}};
         end else begin
            elem_cnt_r <= elem_cnt_r + {{(LEN_W-1){1'b0}}, 1'b1};
         end
      end else begin
         elem_cnt_r <= elem_cnt_r;
         len_r      <= len_r;
      end
   end

   assign capture_s = stage_tag_s[LATENCY-1].valid && stage_tag_s[LATENCY-1].last;

   // Result holding register; a capture in the same cycle as a pop keeps out_valid high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         out_data_r  <= {P_W{1'b0}};
      end else if (capture_s) begin
         out_valid_r <= 1'b1;
         out_data_r  <= dsp_p;
      end else if (out_ready) begin
         out_valid_r <= 1'b0;
         out_data_r  <= out_data_r;
      end else begin
         out_valid_r <= out_valid_r;
         out_data_r  <= out_data_r;
      end
   end

   assign in_ready   = in_ready_s;
   assign dsp_a      = issue_s ? in_a : {OPND_W{1'b0}};
   assign dsp_b      = issue_s ? in_b : {OPND_W{1'b0}};
   assign dsp_c      = {P_W{1'b0}};
   assign dsp_d      = {OPND_W{1'b0}};
   assign dsp_cea    = issue_s;
   assign dsp_ceb    = issue_s;
   assign dsp_cem    = stage_tag_s[0].valid;
   assign dsp_cep    = stage_tag_s[LATENCY-2].valid;
   assign dsp_opmode = tag_opmode(stage_tag_s[OPMODE_DELAY-1]);
   assign out_valid  = out_valid_r;
   assign out_data   = out_data_r;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed self-checking bench for dsp_mac_sequencer with a behavioural
// DSP48A1 slice (A1/B1, M, P registers; OPMODE unregistered).
module tb_dsp_mac_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  cfg_len;
   logic        in_valid;
   logic        in_ready;
   logic [17:0] in_a, in_b;
   logic [17:0] dsp_a, dsp_b, dsp_d;
   logic [47:0] dsp_c;
   logic [7:0]  dsp_opmode;
   logic        dsp_cea, dsp_ceb, dsp_cem, dsp_cep;
   logic [47:0] dsp_p;
   logic        out_valid;
   logic        out_ready;
   logic [47:0] out_data;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   dsp_mac_sequencer #(
      .LEN_W        (8),
      .LATENCY      (3),
      .OPMODE_DELAY (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_len    (cfg_len),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .dsp_a      (dsp_a),
      .dsp_b      (dsp_b),
      .dsp_c      (dsp_c),
      .dsp_d      (dsp_d),
      .dsp_opmode (dsp_opmode),
      .dsp_cea    (dsp_cea),
      .dsp_ceb    (dsp_ceb),
      .dsp_cem    (dsp_cem),
      .dsp_cep    (dsp_cep),
      .dsp_p      (dsp_p),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data)
   );

   // Behavioural DSP48A1: A1REG=B1REG=MREG=PREG=1, OPMODEREG=0, X=M, Z from OPMODE[3:2]
   logic signed [17:0] a1_q = 18'sd0;
   logic signed [17:0] b1_q = 18'sd0;
   logic signed [35:0] m_q  = 36'sd0;
   logic signed [47:0] p_q  = 48'sd0;

   always @(posedge clk) begin
      if (dsp_cea) a1_q <= dsp_a;
      if (dsp_ceb) b1_q <= dsp_b;
      if (dsp_cem) m_q  <= a1_q * b1_q;
      if (dsp_cep) p_q  <= ((dsp_opmode[3:2] == 2'b10) ? p_q : 48'sd0) + {{12{m_q[35]}}, m_q};
   end
   assign dsp_p = p_q;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [17:0] a, input logic [17:0] b);
      in_valid = v;
      in_a     = a;
      in_b     = b;
   endtask

   initial begin
      rst_n = 1'b0; cfg_len = 8'd4; out_ready = 1'b1;
      drive(1'b0, 18'd0, 18'd0);
      tick(); tick();
      // reset state
      check("rst in_ready",   64'(in_ready),   64'd1);
      check("rst out_valid",  64'(out_valid),  64'd0);
      check("rst out_data",   64'(out_data),   64'd0);
      check("rst opmode",     64'(dsp_opmode), 64'h00);
      check("rst ce",         64'({dsp_cea, dsp_ceb, dsp_cem, dsp_cep}), 64'd0);
      check("rst dsp_cd",     64'({dsp_c, dsp_d}), 64'd0);
      rst_n = 1'b1;
      tick();

      // ---- basic dot product, back-to-back: issues in cycles 0..3 ----
      cfg_len = 8'd4;
      drive(1'b1, 18'd1, 18'd5); check("basic ready0", 64'(in_ready), 64'd1);
      #1 check("basic dsp_a0", 64'(dsp_a), 64'd1);
      tick(); drive(1'b1, 18'd2, 18'd6);                  // cycle 1
      check("basic cem c1", 64'(dsp_cem), 64'd1);
      tick(); drive(1'b1, 18'd3, 18'd7);                  // cycle 2
      check("basic opm load", 64'(dsp_opmode), 64'h01);
      tick(); drive(1'b1, 18'd4, 18'd8);                  // cycle 3
      check("basic opm acc", 64'(dsp_opmode), 64'h09);
      tick(); drive(1'b0, 18'd0, 18'd0);                  // cycle 4
      #1 check("basic dsp_a idle", 64'(dsp_a), 64'd0);
      tick(); tick();                                     // cycle 6
      check("basic valid early", 64'(out_valid), 64'd0);
      tick();                                             // cycle 7
      check("basic valid", 64'(out_valid), 64'd1);
      check("basic data",  64'(out_data),  64'd70);
      tick();                                             // cycle 8
      check("basic valid 1cyc", 64'(out_valid), 64'd0);
      tick();

      // ---- bubbles: issues in cycles 0,3,6,9 ----
      drive(1'b1, 18'd1, 18'd5);                          // cycle 0
      tick(); drive(1'b0, 18'd0, 18'd0);                  // cycle 1
      check("bub cem c1", 64'(dsp_cem), 64'd1);
      tick();                                             // cycle 2
      check("bub cem c2", 64'(dsp_cem), 64'd0);
      check("bub cep c2", 64'(dsp_cep), 64'd1);
      tick(); drive(1'b1, 18'd2, 18'd6);                  // cycle 3
      check("bub ce c3", 64'({dsp_cem, dsp_cep}), 64'd0);
      check("bub opm idle", 64'(dsp_opmode), 64'h00);
      tick(); drive(1'b0, 18'd0, 18'd0);                  // cycle 4
      check("bub cem c4", 64'(dsp_cem), 64'd1);
      tick(); tick(); drive(1'b1, 18'd3, 18'd7);          // cycle 6
      tick(); drive(1'b0, 18'd0, 18'd0);                  // cycle 7
      tick(); tick(); drive(1'b1, 18'd4, 18'd8);          // cycle 9
      tick(); drive(1'b0, 18'd0, 18'd0);                  // cycle 10
      tick();                                             // cycle 11
      check("bub cep c11", 64'(dsp_cep), 64'd1);
      check("bub opm c11", 64'(dsp_opmode), 64'h09);
      tick();                                             // cycle 12
      check("bub valid early", 64'(out_valid), 64'd0);
      tick();                                             // cycle 13
      check("bub valid", 64'(out_valid), 64'd1);
      check("bub data",  64'(out_data),  64'd70);
      tick(); tick();

      // ---- signed extremes, len=2: issues in cycles 0,1 ----
      cfg_len = 8'd2;
      drive(1'b1, 18'h20000, 18'h20000);                  // -131072 x -131072
      tick(); drive(1'b1, 18'h1FFFF, 18'h1FFFF);          // 131071 x 131071
      tick(); drive(1'b0, 18'd0, 18'd0);
      tick(); tick(); tick();                             // cycle 5
      check("signed valid", 64'(out_valid), 64'd1);
      check("signed data",  64'(out_data),  64'd34359476225);
      tick(); tick();

      // ---- backpressure with two len=1 vectors ----
      cfg_len = 8'd1; out_ready = 1'b0;
      drive(1'b1, 18'd3, 18'd4);                          // cycle 0
      tick(); drive(1'b1, 18'd5, 18'd6);                  // cycle 1
      check("bp ready inflight", 64'(in_ready), 64'd0);
      check("bp cea stalled",    64'(dsp_cea),  64'd0);
      tick(); tick(); tick(); tick(); tick();             // cycle 6
      check("bp held valid", 64'(out_valid), 64'd1);
      check("bp held data",  64'(out_data),  64'd12);
      check("bp ready held", 64'(in_ready),  64'd0);
      out_ready = 1'b1;
      #1 check("bp ready comb", 64'(in_ready), 64'd1);
      tick(); drive(1'b0, 18'd0, 18'd0);                  // cycle 7
      check("bp popped", 64'(out_valid), 64'd0);
      tick(); tick(); tick();                             // cycle 10
      check("bp second valid", 64'(out_valid), 64'd1);
      check("bp second data",  64'(out_data),  64'd30);
      tick(); tick();

      // ---- cfg_len=0 acts as 1 ----
      cfg_len = 8'd0;
      drive(1'b1, 18'd7, 18'd9);                          // cycle 0
      tick(); drive(1'b0, 18'd0, 18'd0);
      tick(); tick();                                     // cycle 3
      check("len0 early", 64'(out_valid), 64'd0);
      tick();                                             // cycle 4
      check("len0 valid", 64'(out_valid), 64'd1);
      check("len0 data",  64'(out_data),  64'd63);
      tick(); tick();

      // ---- reset mid-vector, then fresh len=2 vector ----
      cfg_len = 8'd4;
      drive(1'b1, 18'd11, 18'd13);                        // cycle 0
      tick(); drive(1'b1, 18'd17, 18'd19);                // cycle 1
      tick(); drive(1'b0, 18'd0, 18'd0);                  // cycle 2
      rst_n = 1'b0;
      #1;
      check("mid rst ce",     64'({dsp_cea, dsp_ceb, dsp_cem, dsp_cep}), 64'd0);
      check("mid rst opmode", 64'(dsp_opmode), 64'h00);
      check("mid rst valid",  64'(out_valid),  64'd0);
      check("mid rst data",   64'(out_data),   64'd0);
      check("mid rst ready",  64'(in_ready),   64'd1);
      tick(); rst_n = 1'b1;                               // cycle 3
      tick();                                             // cycle 4
      cfg_len = 8'd2;
      drive(1'b1, 18'd2, 18'd4);
      tick(); drive(1'b1, 18'd3, 18'd5);                  // cycle 5
      tick(); drive(1'b0, 18'd0, 18'd0);                  // cycle 6
      check("post rst opm load", 64'(dsp_opmode), 64'h01);
      tick(); tick(); tick();                             // cycle 9
      check("post rst valid", 64'(out_valid), 64'd1);
      check("post rst data",  64'(out_data),  64'd23);
      tick(); tick();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
